md_unit: RTL and testbench

Multiply/divide controller for the E stage of the five-stage pipeline. It accepts one mult/multu/div/divu/mthi/mtlo operation per issue, sequences it over a fixed multi-cycle latency, and owns the architectural HI/LO registers. It drives a stall request so the hazard unit holds any HI/LO-using instruction in D while an operation is pending.

---
 rtl/md_unit.sv | 132 +++++++++++++
 tb/tb_md_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide sequencer owning HI/LO, fixed MULT_CYCLES/DIV_CYCLES latency.
// Optional build macro MD_DIVZERO_HOLD_EN: divide by zero is dropped instead of producing {a, all-ones}.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [63:0]   r_pend;

  logic        w_is_md;
  logic        w_is_div;
  logic        w_signed;
  logic        w_idle;
  logic        w_last;
  logic        w_skip;
  logic        w_launch;
  logic        w_mthi;
  logic        w_mtlo;
  logic [63:0] w_prod;
  logic        w_a_neg;
  logic        w_b_neg;
  logic        w_b_zero;
  logic [31:0] w_dvd;
  logic [31:0] w_dvs;
  logic [31:0] w_dvs_safe;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [63:0] w_div_res;
  logic [63:0] w_res;

  assign w_is_md  = ~op[2];
  assign w_is_div = ~op[2] & op[1];
  assign w_signed = ~op[0];

  always_comb begin
    w_prod = 64'd0;
    if (w_signed)
      w_prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    else
      w_prod = {32'd0, a} * {32'd0, b};
  end

  // Signed division via magnitudes; -2^31 / -1 wraps to 32'h80000000 rem 0.
  assign w_a_neg    = w_signed & a[31];
  assign w_b_neg    = w_signed & b[31];
  assign w_b_zero   = (b == 32'd0);
  assign w_dvd      = w_a_neg ? (~a + 32'd1) : a;
  assign w_dvs      = w_b_neg ? (~b + 32'd1) : b;
  assign w_dvs_safe = w_b_zero ? 32'd1 : w_dvs;
  assign w_uq       = w_dvd / w_dvs_safe;
  assign w_ur       = w_dvd % w_dvs_safe;
  assign w_q        = (w_a_neg ^ w_b_neg) ? (~w_uq + 32'd1) : w_uq;
  assign w_r        = w_a_neg ? (~w_ur + 32'd1) : w_ur;
  assign w_div_res  = w_b_zero ? {a, 32'hFFFF_FFFF} : {w_r, w_q};
  assign w_res      = w_is_div ? w_div_res : w_prod;

  assign w_idle = (r_state == S_IDLE);
  assign w_last = (r_state == S_RUN) && (r_cnt == CW'(1));

`ifdef MD_DIVZERO_HOLD_EN
  assign w_skip = w_is_div & w_b_zero;
`else
  assign w_skip = 1'b0;
`endif

  assign w_launch = start & w_idle & w_is_md & ~w_skip;
  assign w_mthi   = start & w_idle & (op == 3'd4);
  assign w_mtlo   = start & w_idle & (op == 3'd5);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_pend  <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_state <= S_RUN;
            r_pend  <= w_res;
            r_cnt   <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          end else begin
            if (w_mthi) r_hi <= a;
            if (w_mtlo) r_lo <= a;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_state <= S_IDLE;
            r_hi    <= r_pend[63:32];
            r_lo    <= r_pend[31:0];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (r_state == S_RUN);
  assign done  = w_last;
  assign stall = md_use_D & (busy | (start & w_is_md));
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Table-driven and randomized bench for md_unit against an integer-arithmetic reference model.
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use_D;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .md_use_D(md_use_D), .busy(busy), .stall(stall), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && busy && start) begin
      errors++;
      $display("FAIL start_in_run actual=1 required=0 at %0t", $time);
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ud;
    logic [31:0] eh;
    logic [31:0] el;
    int          n;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                                input logic [31:0] mh, input logic [31:0] ml,
                                output logic [31:0] nh, output logic [31:0] nl, output int n);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur, p;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = {32'd0, av};
    ub = {32'd0, bv};
    nh = mh; nl = ml; n = 0;
    case (o)
      3'd0: begin p = longint'(sa * sb); nh = p[63:32]; nl = p[31:0]; n = MC; end
      3'd1: begin p = ua * ub; nh = p[63:32]; nl = p[31:0]; n = MC; end
      3'd2, 3'd3: begin
        if (bv == 32'd0) begin
`ifdef MD_DIVZERO_HOLD_EN
          n = 0;
`else
          nh = av; nl = 32'hFFFF_FFFF; n = DC;
`endif
        end else if (o == 3'd2) begin
          q = sa / sb; r = sa % sb; nh = r[31:0]; nl = q[31:0]; n = DC;
        end else begin
          uq = ua / ub; ur = ua % ub; nh = ur[31:0]; nl = uq[31:0]; n = DC;
        end
      end
      3'd4: nh = av;
      3'd5: nl = av;
      default: ;
    endcase
  endfunction

  // Issues one op in the current cycle and follows it to completion.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic ud, input logic [31:0] eh, input logic [31:0] el,
                        input int en, input string nm);
    int n, dn_cnt, dn_at;
    start = 1'b1; op = o; a = av; b = bv; md_use_D = ud;
    #1;
    chk({nm, "_stall_T"}, 64'(stall), 64'(ud & (o <= 3'd3)));
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    n = 0; dn_cnt = 0; dn_at = -1;
    while (busy && n < 60) begin
      #1;
      if (stall !== ud) chk({nm, "_stall_busy"}, 64'(stall), 64'(ud));
      if (done) begin dn_cnt++; dn_at = n + 1; end
      n++;
      @(posedge clk); #1;
    end
    chk({nm, "_busy_cycles"}, 64'(n), 64'(en));
    chk({nm, "_done_pulses"}, 64'(dn_cnt), (en > 0) ? 64'd1 : 64'd0);
    if (en > 0) chk({nm, "_done_cycle"}, 64'(dn_at), 64'(en));
    chk({nm, "_busy_after"}, 64'(busy), 64'd0);
    chk({nm, "_done_after"}, 64'(done), 64'd0);
    #1;
    chk({nm, "_stall_after"}, 64'(stall), 64'd0);
    chk({nm, "_hi"}, 64'(hi), 64'(eh));
    chk({nm, "_lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    logic [31:0] m_hi, m_lo, nh, nl, av, bv;
    logic [2:0]  o;
    int          n, dn;

    tv[0]  = '{3'd0, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MC};
    tv[1]  = '{3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 32'h0000_0006, 32'hFFFF_FFEB, MC};
    tv[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
    tv[3]  = '{3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h0000_0001, 32'h7FFF_FFFC, DC};
    tv[4]  = '{3'd4, 32'h1234_5678, 32'd9, 1'b1, 32'h1234_5678, 32'h7FFF_FFFC, 0};
    tv[5]  = '{3'd5, 32'h9ABC_DEF0, 32'd9, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 0};
`ifdef MD_DIVZERO_HOLD_EN
    tv[6]  = '{3'd2, 32'd5, 32'd0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 0};
    tv[7]  = '{3'd7, 32'hDEAD_BEEF, 32'd1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 0};
`else
    tv[6]  = '{3'd2, 32'd5, 32'd0, 1'b1, 32'h0000_0005, 32'hFFFF_FFFF, DC};
    tv[7]  = '{3'd7, 32'hDEAD_BEEF, 32'd1, 1'b1, 32'h0000_0005, 32'hFFFF_FFFF, 0};
`endif
    tv[8]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000, MC};
    tv[9]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000, DC};
`ifdef MD_DIVZERO_HOLD_EN
    tv[10] = '{3'd3, 32'd5, 32'd0, 1'b0, 32'h0000_0000, 32'h8000_0000, 0};
`else
    tv[10] = '{3'd3, 32'd5, 32'd0, 1'b0, 32'h0000_0005, 32'hFFFF_FFFF, DC};
`endif
    tv[11] = '{3'd2, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD, DC};

    reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; md_use_D = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op(tv[i].op, tv[i].a, tv[i].b, tv[i].ud, tv[i].eh, tv[i].el, tv[i].n,
             $sformatf("vec%0d", i));

    // Reset lands in busy cycle 3 of a div; the pending result must vanish.
    start = 1'b1; op = 3'd2; a = 32'hFFFF_FFF9; b = 32'd2; md_use_D = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstmid_busy_c3", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_done", 64'(done), 64'd0);
    chk("rstmid_hi", 64'(hi), 64'd0);
    chk("rstmid_lo", 64'(lo), 64'd0);
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      if (done || busy) dn++;
      @(posedge clk); #1;
    end
    chk("rstmid_no_done", 64'(dn), 64'd0);
    chk("rstmid_hi_kept", 64'(hi), 64'd0);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MC, "post_rst_mult");
    m_hi = 32'hFFFF_FFFF;
    m_lo = 32'hFFFF_FFEB;

    for (int i = 0; i < 40; i++) begin
      o  = 3'($urandom_range(0, 7));
      av = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0: bv = $urandom;
        1: bv = 32'd0;
        2: bv = 32'($urandom_range(1, 9));
        default: bv = 32'hFFFF_FFFF;
      endcase
      model(o, av, bv, m_hi, m_lo, nh, nl, n);
      run_op(o, av, bv, 1'($urandom_range(0, 1)), nh, nl, n, $sformatf("rnd%0d_op%0d", i, o));
      m_hi = nh;
      m_lo = nl;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
